// File: rtl/spi_slave_responder_if.sv
// Bus bundle for spi_slave_responder.
// Groups the SPI pins and the local reply/receive handshake so the responder
// and whoever drives it share one set of names.
//   slave modport  : view from the responder (SPI pins in, MISO out,
//                    tx word in, rx word and status pulses out)
//   master modport : view from the SPI master / local logic side
// Handshake: a reply word moves on tx_valid && tx_ready, sampled at the
// rising clk edge; tx_valid raised while tx_ready is low is ignored (no
// overwrite). rx_valid is a one-cycle pulse with no backpressure.
// dbg_state exposes the responder FSM state for observation.
interface spi_slave_responder_if #(
    parameter int DATA_W = 32
);
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_abort;
    logic              busy;
    logic [1:0]        dbg_state;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_abort, busy, dbg_state
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder endpoint. Receives a DATA_W-bit MSB-first word on MOSI
// while shifting a preloaded reply out on MISO in the same frame. All SPI
// pins are oversampled in the clk domain (clk must be >= 8x SCLK).
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_slave_responder_if.slave (SPI pins, tx/rx handshake,
//              status pulses, busy, dbg_state)
module spi_slave_responder #(
    parameter int                DATA_W      = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = '0
) (
    input logic                  clk,
    input logic                  rst,
    spi_slave_responder_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_WAIT_CS = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q,  sclk_dly_d;
    logic                   cs_dly_q,    cs_dly_d;
    logic [SYNC_STAGES:0]   primed_q,    primed_d;
    logic [1:0]             state_q,     state_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0]      rx_shift_q,  rx_shift_d;
    logic [DATA_W-1:0]      tx_shift_q,  tx_shift_d;
    logic [DATA_W-1:0]      hold_data_q, hold_data_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_W-1:0]      rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_abort_q, frame_abort_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise =  sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s &  sclk_dly_q;
    assign cs_fall   = ~cs_s   &  cs_dly_q;
    assign cs_rise   =  cs_s   & ~cs_dly_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sclk_dly_d  = sclk_s;
        cs_dly_d    = cs_s;
        // The synchroniser reset values are placeholders, not the real pin.
        // primed_q fills with ones once the live CS level has reached both
        // cs_s and cs_dly_q, so a CS held low across reset cannot look like
        // "CS high" and let the FSM leave WAIT_CS early.
        primed_d    = {primed_q[SYNC_STAGES-1:0], 1'b1};

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_data_d   = hold_data_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;

        // Load only into an empty holding register. A frame start takes the
        // word only when it was already full, so a load in the same cycle as
        // cs_fall never feeds that frame; it waits for the next one.
        if (bus.tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    if (hold_full_q) begin
                        tx_shift_d  = hold_data_q;
                        hold_full_d = 1'b0;
                    end else begin
                        tx_shift_d    = IDLE_FILL;
                        tx_underrun_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_CNT) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_WAIT_CS;
                end else if (cs_rise) begin
                    frame_abort_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                    // The first falling edge only ends bit 0's low phase
                    // before any rise; MSB must stay on MISO until sampled.
                    if (sclk_fall && (bit_cnt_q != '0)) begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            ST_WAIT_CS: begin
                if (cs_s && primed_q[SYNC_STAGES]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_CS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '1;
            sclk_dly_q    <= 1'b0;
            cs_dly_q      <= 1'b1;
            primed_q      <= '0;
            state_q       <= ST_WAIT_CS;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_data_q   <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_dly_q    <= sclk_dly_d;
            cs_dly_q      <= cs_dly_d;
            primed_q      <= primed_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_data_q   <= hold_data_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign bus.spi_miso    = (state_q == ST_SHIFT) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign bus.spi_miso_oe = ((state_q == ST_SHIFT) || (state_q == ST_WAIT_CS)) ? ~cs_s : 1'b0;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.dbg_state   = state_q;
endmodule
